// File: rtl/uart_port.sv
// uart_port: 8N1 UART endpoint for the J1B CPU strobe interface.
// A TX FIFO feeds a serializer driving uart_tx. A deserializer on the
// synchronized uart_rx line fills an RX FIFO whose head is presented to the CPU.
module uart_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  // Last count of a bit period, and the mid-point of the start bit.
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr;
  logic           tx_empty, tx_full, tx_push, tx_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign tx_push  = uart0_wr && (!tx_full || tx_pop);

  // Store written bytes.
  // NOTE: FIFO storage has no reset; the pointers alone define what is valid,
  // and leaving the array unreset lets it map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= uart_w;
  end

  // Advance TX FIFO pointers on push/pop.
  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit_idx;
  logic [7:0]       tx_shift;
  logic             tx_tick;
  logic             tx_line_d, tx_busy_d, tx_overflow_d;

  assign tx_tick = (tx_state_q != TX_IDLE) && (tx_cnt == BIT_LAST);
  // The FIFO head is popped and loaded into the shifter on every entry to START.
  assign tx_pop  = !tx_empty &&
                   ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_tick));

  // TX state register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) tx_state_q <= TX_IDLE;
    else         tx_state_q <= tx_state_d;
  end

  // TX next-state: each state/bit lasts one full bit period.
  // NOTE: defaulting every combinational output before the case means no path
  // leaves a variable unassigned, so no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (!tx_empty) tx_state_d = TX_START;
      TX_START: if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit_idx == 3'd7)) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_d = tx_empty ? TX_IDLE : TX_START;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: line level for the current state, busy and overflow flags.
  always_comb begin
    tx_line_d     = 1'b1;
    tx_busy_d     = (tx_state_q != TX_IDLE) || !tx_empty;
    tx_overflow_d = uart0_wr && tx_full && !tx_pop;
    case (tx_state_q)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // TX baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      tx_shift   <= '0;
    end else begin
      if ((tx_state_q == TX_IDLE) || tx_tick) tx_cnt <= '0;
      else                                    tx_cnt <= tx_cnt + CNT_W'(1);
      if (tx_pop) begin
        tx_shift   <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
        tx_bit_idx <= '0;
      end else if ((tx_state_q == TX_DATA) && tx_tick) begin
        tx_shift   <= {1'b0, tx_shift[7:1]};
        tx_bit_idx <= tx_bit_idx + 3'd1;
      end
    end
  end

  // Registered TX-side outputs; uart_tx lags the state by one clock.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      uart_tx     <= 1'b1;
      tx_busy     <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      uart_tx     <= tx_line_d;
      tx_busy     <= tx_busy_d;
      tx_overflow <= tx_overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchronizer
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;
  logic           rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]     rx_shift;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_pop   = uart0_rd && !rx_empty;

  assign uart0_valid = !rx_empty;
  assign uart0_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[RX_AW-1:0]];

  // Store received bytes.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_shift;
  end

  // Advance RX FIFO pointers on push/pop.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RX deserializer
  // ---------------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit_idx;
  logic             rx_half, rx_bit_tick, rx_stop_tick;
  logic             rx_overrun_d, rx_frame_err_d;

  assign rx_half      = (rx_state_q == RX_START) && (rx_cnt == BIT_HALF);
  assign rx_bit_tick  = (rx_state_q == RX_DATA)  && (rx_cnt == BIT_LAST);
  assign rx_stop_tick = (rx_state_q == RX_STOP)  && (rx_cnt == BIT_LAST);

  // RX state register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rx_state_q <= RX_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  // RX next-state: start edge, mid-start glitch check, 8 data bits, stop.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_d = RX_START;
      RX_START: if (rx_half) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_tick && (rx_bit_idx == 3'd7)) rx_state_d = RX_STOP;
      // Leave at mid-stop so a following start edge is not missed.
      RX_STOP:  if (rx_stop_tick) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs: push a good byte, or flag overrun / framing error.
  always_comb begin
    rx_push        = rx_stop_tick && rx_sync && (!rx_full || rx_pop);
    rx_overrun_d   = rx_stop_tick && rx_sync && rx_full && !rx_pop;
    rx_frame_err_d = rx_stop_tick && !rx_sync;
  end

  // RX baud counter, bit index and shift register (LSB arrives first).
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
    end else begin
      if ((rx_state_q == RX_IDLE) || rx_half || (rx_cnt == BIT_LAST)) rx_cnt <= '0;
      else                                                             rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_state_q == RX_START) rx_bit_idx <= '0;
      else if (rx_bit_tick)       rx_bit_idx <= rx_bit_idx + 3'd1;
      if (rx_bit_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // Registered RX status pulses.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= rx_overrun_d;
      rx_frame_err <= rx_frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: directed scoreboard bench for uart_port with CLKS_PER_BIT=8.
// Stimulus pushes expected TX frames / RX bytes into queues; independent
// monitors decode uart_tx and observe CPU reads, then pop and compare.
module tb_uart_port;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       resetq;
  logic       uart0_wr;
  logic [7:0] uart_w;
  logic       uart0_rd;
  logic       uart0_valid;
  logic [7:0] uart0_data;
  logic       uart_tx;
  logic       uart_rx;
  logic       tx_busy;
  logic       tx_overflow;
  logic       rx_overrun;
  logic       rx_frame_err;

  uart_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(16), .RX_DEPTH(4)) dut (
    .clk          (clk),
    .resetq       (resetq),
    .uart0_wr     (uart0_wr),
    .uart_w       (uart_w),
    .uart0_rd     (uart0_rd),
    .uart0_valid  (uart0_valid),
    .uart0_data   (uart0_data),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .tx_busy      (tx_busy),
    .tx_overflow  (tx_overflow),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  logic [7:0] rx_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_count = 0;
  int n_txovf = 0;
  int n_rxovr = 0;
  int n_ferr = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge resetq) rst_count = rst_count + 1;

  always @(negedge clk) begin
    if (tx_overflow)  n_txovf = n_txovf + 1;
    if (rx_overrun)   n_rxovr = n_rxovr + 1;
    if (rx_frame_err) n_ferr  = n_ferr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TX monitor: decode each frame on uart_tx at bit centres and score it.
  initial begin : tx_monitor
    int         start_cyc, prev_start, rst_mark;
    logic [7:0] d;
    logic       sb, sp;
    tx_exp_t    e;
    prev_start = 0;
    forever begin
      @(negedge clk);
      if (resetq === 1'b1 && uart_tx === 1'b0) begin
        start_cyc = cyc;
        rst_mark  = rst_count;
        repeat (CPB / 2) @(negedge clk);
        sb = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        sp = uart_tx;
        // Frames interrupted by reset are abandoned, not scored.
        if (rst_mark == rst_count) begin
          if (tx_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL tx_unexpected_frame: got %02h, none expected", d);
          end else begin
            e = tx_q.pop_front();
            check("tx_start_bit", sb, 0);
            check("tx_data", d, e.data);
            check("tx_stop_bit", sp, 1);
            if (e.b2b) check("tx_frame_spacing", start_cyc - prev_start, 10 * CPB);
          end
        end
        prev_start = start_cyc;
      end
    end
  end

  // RX monitor: whenever the CPU reads a valid head, compare it to the queue.
  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      #3;
      if (resetq === 1'b1 && uart0_rd === 1'b1 && uart0_valid === 1'b1) begin
        if (rx_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rx_unexpected_read: got %02h, none expected", uart0_data);
        end else begin
          check("rx_data", uart0_data, rx_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one 8N1 frame on uart_rx, one bit per CPB clocks (called at a negedge).
  task automatic rx_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // One-cycle read strobe (called at a negedge, returns at the next negedge).
  task automatic do_read();
    uart0_rd = 1'b1;
    @(negedge clk);
    uart0_rd = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (uart0_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, uart0_valid, 1);
  endtask

  task automatic wait_tx_drain(input int budget, input string name);
    int k = 0;
    while ((tx_q.size() != 0 || tx_busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, tx_q.size(), 0);
  endtask

  initial begin : stimulus
    logic [9:0] pat;
    int         base;
    int         low_cycles;

    uart0_wr = 1'b0;
    uart_w   = 8'h00;
    uart0_rd = 1'b0;
    uart_rx  = 1'b1;
    resetq   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_valid", uart0_valid, 0);
    check("rst_data", uart0_data, 8'h00);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_pulses", {tx_overflow, rx_overrun, rx_frame_err}, 3'b000);
    resetq = 1'b1;
    repeat (3) @(negedge clk);

    // TX single byte A5: line falls two edges after the write edge N.
    tx_q.push_back('{data: 8'hA5, b2b: 1'b0});
    uart_w   = 8'hA5;
    uart0_wr = 1'b1;
    @(negedge clk);                      // after edge N
    uart0_wr = 1'b0;
    check("tx1_line_n", uart_tx, 1);
    check("tx1_busy_n", tx_busy, 0);
    @(negedge clk);                      // after N+1
    check("tx1_line_n1", uart_tx, 1);
    check("tx1_busy_n1", tx_busy, 1);
    @(negedge clk);                      // after N+2
    check("tx1_line_n2", uart_tx, 0);
    pat = 10'b11_0100_1010;              // start, A5 LSB first, stop
    repeat (CPB / 2) @(negedge clk);     // after N+6, mid bit 0
    check("tx1_bit0", uart_tx, pat[0]);
    for (int k = 1; k < 10; k++) begin
      repeat (CPB) @(negedge clk);
      check("tx1_bit", uart_tx, pat[k]);
    end
    repeat (3) @(negedge clk);           // after N+81
    check("tx1_busy_n81", tx_busy, 1);
    @(negedge clk);                      // after N+82
    check("tx1_busy_n82", tx_busy, 0);
    check("tx1_line_idle", uart_tx, 1);
    repeat (4) @(negedge clk);

    // TX overflow: 18 back-to-back writes; 0x00 pops at once, 0x01..0x10 fill
    // the FIFO, 0x11 is dropped.
    base = n_txovf;
    for (int i = 0; i < 18; i++) begin
      uart_w   = 8'(i);
      uart0_wr = 1'b1;
      if (i <= 16) tx_q.push_back('{data: 8'(i), b2b: (i > 0)});
      @(negedge clk);
    end
    uart0_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("tx_overflow_pulses", n_txovf - base, 1);
    wait_tx_drain(2000, "tx_burst_drained");
    repeat (4) @(negedge clk);

    // RX loopback 3C, then read it out.
    rx_q.push_back(8'h3C);
    rx_send(8'h3C, 1'b1);
    wait_valid(4 * CPB, "rx1_valid");
    check("rx1_head", uart0_data, 8'h3C);
    do_read();
    check("rx1_valid_after_rd", uart0_valid, 0);
    check("rx1_data_after_rd", uart0_data, 8'h00);
    repeat (4) @(negedge clk);

    // RX overrun: five frames with no reads; the fifth is dropped.
    base = n_rxovr;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) rx_q.push_back(8'(i));
      rx_send(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    check("rx_overrun_pulses", n_rxovr - base, 1);
    check("rx_full_valid", uart0_valid, 1);
    for (int i = 0; i < 4; i++) do_read();
    check("rx_drained_valid", uart0_valid, 0);
    check("rx_drained_data", uart0_data, 8'h00);

    // Read strobe on an empty FIFO is ignored.
    do_read();
    check("rx_empty_rd_valid", uart0_valid, 0);
    repeat (4) @(negedge clk);

    // Short glitch on uart_rx: no byte, no error.
    base = n_ferr;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("rx_glitch_valid", uart0_valid, 0);
    check("rx_glitch_ferr", n_ferr - base, 0);

    // Frame with stop bit 0: framing error, byte discarded.
    rx_send(8'h5A, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("rx_ferr_pulses", n_ferr - base, 1);
    check("rx_ferr_valid", uart0_valid, 0);

    // Reset mid-frame: fill RX with one byte and TX with three, then reset in bit 3.
    rx_send(8'h77, 1'b1);
    wait_valid(4 * CPB, "rst_pre_rx_valid");
    uart_w   = 8'h00;
    uart0_wr = 1'b1;
    @(negedge clk);                      // after edge N
    uart_w = 8'h55;
    @(negedge clk);
    uart_w = 8'h66;
    @(negedge clk);                      // after N+2
    uart0_wr = 1'b0;
    repeat (35) @(negedge clk);          // after N+37, inside data bit 3
    check("rst_pre_bit3", uart_tx, 0);
    #2;
    resetq = 1'b0;
    #1;
    check("rst_async_tx", uart_tx, 1);
    check("rst_async_busy", tx_busy, 0);
    check("rst_async_valid", uart0_valid, 0);
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    low_cycles = 0;
    for (int k = 0; k < 25 * CPB; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_cycles++;
    end
    check("rst_no_residual_tx", low_cycles, 0);
    check("rst_post_busy", tx_busy, 0);
    check("rst_post_rx_valid", uart0_valid, 0);

    // The TX FIFO restarts clean: only the new byte is sent.
    tx_q.push_back('{data: 8'hC3, b2b: 1'b0});
    uart_w   = 8'hC3;
    uart0_wr = 1'b1;
    @(negedge clk);
    uart0_wr = 1'b0;
    wait_tx_drain(20 * CPB, "post_rst_tx_drained");
    repeat (4) @(negedge clk);
    check("rx_queue_consumed", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
